// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for dmem_arbiter: two req/ack ports plus shared read data and busy.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-port sync dmem between two req/ack requesters.
// Latency: write acks at T+1 (2-cycle rate), read acks with rdata at T+3 (4-cycle rate).
// Backpressure: one transaction in flight; a losing requester holds req until granted.
module dmem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     req_if,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam bit FIXED = (FIXED_PRIO != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              win;
    logic              last_gnt;
    logic              we_q;
    logic              ack0_q, ack1_q, busy_q;
    logic [DATA_W-1:0] rdata_q;

    logic              grant;
    logic              pick;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              wren_nxt;
    logic              ack0_nxt, ack1_nxt;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        wren_nxt  = 1'b0;
        ack0_nxt  = 1'b0;
        ack1_nxt  = 1'b0;
        // On a tie the port not granted last wins, unless port 0 has fixed priority.
        if (req_if.req0 && req_if.req1)
            pick = FIXED ? 1'b0 : ~last_gnt;
        else
            pick = req_if.req1;
        we_sel    = pick ? req_if.we1    : req_if.we0;
        addr_sel  = pick ? req_if.addr1  : req_if.addr0;
        wdata_sel = pick ? req_if.wdata1 : req_if.wdata0;

        case (state)
            IDLE: begin
                if (req_if.req0 || req_if.req1) begin
                    grant     = 1'b1;
                    state_nxt = ISSUE;
                    wren_nxt  = we_sel;
                    // Writes complete in ISSUE, so their ack is registered alongside mem_wren.
                    ack0_nxt  = we_sel & ~pick;
                    ack1_nxt  = we_sel &  pick;
                end
            end
            ISSUE:   state_nxt = we_q ? IDLE : CAPTURE;
            CAPTURE: begin
                state_nxt = RESP;
                ack0_nxt  = ~win;
                ack1_nxt  =  win;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win         <= 1'b0;
            last_gnt    <= 1'b1;
            we_q        <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state    <= state_nxt;
            mem_wren <= wren_nxt;
            ack0_q   <= ack0_nxt;
            ack1_q   <= ack1_nxt;
            busy_q   <= (state_nxt != IDLE);
            if (grant) begin
                win         <= pick;
                last_gnt    <= pick;
                we_q        <= we_sel;
                mem_address <= addr_sel;
                mem_data    <= wdata_sel;
            end
            if (state == CAPTURE)
                rdata_q <= mem_q;
        end
    end

    assign req_if.ack0  = ack0_q;
    assign req_if.ack1  = ack1_q;
    assign req_if.busy  = busy_q;
    assign req_if.rdata = rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port synchronous data memory between two requesters: port 0 (CPU load/store path) and port 1 (peripheral path, e.g. PS2 key writer or display reader). It captures one request per transaction with a req/ack handshake, drives the memory's address/data/write-enable from registers, and returns read data once the memory's one-cycle read latency has elapsed. It sits between the requesters and the dmem instance, on the same clock as dmem.

## Interface
- ADDR_W, 12, memory word-address width
- DATA_W, 32, data width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins ties

- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req0, req1  in  1 each  request; held high until the matching ack
- we0, we1  in  1 each  1 = write, 0 = read; sampled at grant
- addr0, addr1  in  ADDR_W each  word address; sampled at grant
- wdata0, wdata1  in  DATA_W each  write data; sampled at grant
- ack0, ack1  out  1 each  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid only while ack0 or ack1 is high after a read
- busy  out  1  high in every state except IDLE
- mem_address  out  ADDR_W  to dmem address, registered
- mem_data  out  DATA_W  to dmem data, registered
- mem_wren  out  1  to dmem wren, registered
- mem_q  in  DATA_W  from dmem q; valid the cycle after the address is presented

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if any req is high, pick a winner. Latch its we/addr/wdata into mem_* registers and latch the winner id. Go to ISSUE. With no req, stay in IDLE.
- Arbitration:
  - FIXED_PRIO=0: on a tie, the port not granted last wins. The last-grant pointer updates at each grant.
  - FIXED_PRIO=1: port 0 wins every tie.
  - A single requester always wins.
- ISSUE, write: mem_wren=1 for this cycle only. Pulse ack of the winner. Go to IDLE.
- ISSUE, read: mem_wren=0, address held. Go to CAPTURE.
- CAPTURE: register mem_q into rdata. Go to RESP.
- RESP: pulse ack of the winner; rdata is valid. Go to IDLE.
- mem_address/mem_data hold their last values outside transactions. mem_wren is 0 in every state except ISSUE of a write.
- A requester must drop or change req in the cycle after its ack. req still high in IDLE after an ack counts as a new request.
- If req drops before ack, the transaction already granted still completes and acks. Inputs are not re-sampled after grant.
- Only one transaction is in flight at a time; there is no queuing.

## Timing
- Reset values:
  - state=IDLE, mem_address=0, mem_data=0, mem_wren=0
  - ack0=ack1=0, rdata=0, busy=0
  - last-grant pointer = port 1, so port 0 wins the first tie
- Reset asserted mid-transaction aborts it: no ack, mem_wren drops to 0 asynchronously.
- Write latency: req seen in IDLE at cycle T; mem_wren=1 and ack in T+1; arbiter back in IDLE at T+2. Peak rate is 1 write per 2 cycles.
- Read latency: req at T; address on mem_address in T+1; mem_q valid in T+2 and captured; ack plus rdata in T+3; IDLE at T+4. Peak rate is 1 read per 4 cycles.
- All outputs are registered; there are no combinational paths from req/addr to mem_* or ack.
- A simultaneous req0 and req1 in IDLE results in exactly one grant. The loser keeps req high and is granted at the next IDLE.
- busy=1 from T+1 through the last cycle before returning to IDLE.

## Test plan
- Reset, then port-0 write addr=0x005 data=0xDEADBEEF -> mem_wren=1 with mem_address=0x005 and mem_data=0xDEADBEEF in T+1; ack0 pulses in T+1; ack1 stays 0.
- Port-1 read addr=0x005 after that write, using a dmem model with 1-cycle latency -> ack1 in T+3 with rdata=0xDEADBEEF; mem_wren stays 0 throughout.
- FIXED_PRIO=0, req0 and req1 both held continuously, both writes -> grants alternate 0,1,0,1; each ack arrives 2 cycles apart; no port gets two grants in a row.
- FIXED_PRIO=1, the same stimulus -> only port 0 is granted while it keeps requesting; port 1 is granted the first IDLE cycle that req0 is low.
- Read granted, then reset driven low in CAPTURE -> all outputs return to reset values immediately; no ack after release; the next req0 is granted normally.
- req1 read dropped one cycle after grant -> ack1 still pulses in T+3 with the correct rdata; arbiter returns to IDLE with no extra grant.
